idu_pipe: RTL and testbench

- Parametrised, registered RISC-V decode stage between fetch (IFU) and execute (EXU).
- Supports RV32I/RV64I by parameter and uses a valid/ready handshake on both sides.
- Decodes the instruction type, full XLEN sign-extended immediate, register indices and enables, illegal-instruction and ebreak flags.
- Provides a sticky halt on ebreak, flush support and a decoded-instruction counter.

---
 rtl/idu_pipe.sv | 128 ++++++++++++
 tb/tb_idu_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/idu_pipe.sv
// idu_pipe: registered RV32I/RV64I decode stage (in_* from fetch, out_* bundle to execute, valid/ready both sides, sticky halt on ebreak, decode_cnt of output handshakes)
module idu_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_rs1_en,
  output logic             out_rs2_en,
  output logic             out_rd_we,
  output logic [2:0]       out_itype,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_word,
  output logic             out_illegal,
  output logic             out_ebreak,
  output logic             halt,
  output logic [CNT_W-1:0] decode_cnt
);
  localparam logic [2:0] IT_R = 3'd0, IT_I = 3'd1, IT_S = 3'd2, IT_B = 3'd3;
  localparam logic [2:0] IT_U = 3'd4, IT_J = 3'd5, IT_SYS = 3'd6, IT_BAD = 3'd7;
  localparam bit RV64 = XLEN == 64;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_we;
    logic [2:0]      itype;
    logic [XLEN-1:0] imm;
    logic            word;
    logic            illegal;
    logic            ebreak;
  } bnd_t;
  bnd_t dec, bnd_d, bnd_q;
  logic out_valid_d, out_valid_q, halt_d, halt_q, acc, hs, load, w_op;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [6:0] op;
  logic [31:0] imm32;
  always_comb begin
    dec = '0;
    op = in_inst[6:0];
    w_op = op == 7'b0011011 || op == 7'b0111011;
    dec.itype = (op == 7'b0110011 || (op == 7'b0111011 && RV64)) ? IT_R :
                (op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111 || (op == 7'b0011011 && RV64)) ? IT_I :
                op == 7'b0100011 ? IT_S :
                op == 7'b1100011 ? IT_B :
                (op == 7'b0110111 || op == 7'b0010111) ? IT_U :
                op == 7'b1101111 ? IT_J :
                op == 7'b1110011 ? IT_SYS : IT_BAD;
    imm32 = dec.itype == IT_I ? {{20{in_inst[31]}}, in_inst[31:20]} :
            dec.itype == IT_S ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]} :
            dec.itype == IT_B ? {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
            dec.itype == IT_U ? {in_inst[31:12], 12'b0} :
            dec.itype == IT_J ? {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} : 32'b0;
    dec.pc = in_pc;
    dec.opcode = op;
    dec.funct3 = in_inst[14:12];
    dec.funct7 = in_inst[31:25];
    dec.rs1 = (dec.itype == IT_U || dec.itype == IT_J) ? 5'd0 : in_inst[19:15];
    dec.rs2 = in_inst[24:20];
    dec.rd = in_inst[11:7];
    dec.rs1_en = dec.itype inside {IT_R, IT_I, IT_S, IT_B};
    dec.rs2_en = dec.itype inside {IT_R, IT_S, IT_B};
    dec.rd_we = dec.itype inside {IT_R, IT_I, IT_U, IT_J} && in_inst[11:7] != 5'd0;
    dec.imm = XLEN'($signed(imm32));
    dec.word = w_op && RV64;
    dec.illegal = dec.itype == IT_BAD;
    dec.ebreak = in_inst == 32'h0010_0073;
    in_ready = !halt_q && (!out_valid_q || out_ready);
    acc = in_valid && in_ready;
    hs = out_valid_q && out_ready;
    load = acc && !flush;
    out_valid_d = !flush && (acc || (out_valid_q && !out_ready));
    bnd_d = load ? dec : bnd_q;
    halt_d = halt_q || (load && dec.ebreak);
    cnt_d = cnt_q + CNT_W'(hs);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bnd_q <= '0;
      out_valid_q <= 1'b0;
      halt_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      bnd_q <= bnd_d;
      out_valid_q <= out_valid_d;
      halt_q <= halt_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = out_valid_q;
  assign halt = halt_q;
  assign decode_cnt = cnt_q;
  assign out_pc = bnd_q.pc;
  assign out_opcode = bnd_q.opcode;
  assign out_funct3 = bnd_q.funct3;
  assign out_funct7 = bnd_q.funct7;
  assign out_rs1 = bnd_q.rs1;
  assign out_rs2 = bnd_q.rs2;
  assign out_rd = bnd_q.rd;
  assign out_rs1_en = bnd_q.rs1_en;
  assign out_rs2_en = bnd_q.rs2_en;
  assign out_rd_we = bnd_q.rd_we;
  assign out_itype = bnd_q.itype;
  assign out_imm = bnd_q.imm;
  assign out_word = bnd_q.word;
  assign out_illegal = bnd_q.illegal;
  assign out_ebreak = bnd_q.ebreak;
endmodule

// File: tb/tb_idu_pipe.sv
// tb_idu_pipe: scoreboard bench driving an RV64 and an RV32 idu_pipe with the same directed instruction stream
module tb_idu_pipe;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n, flush, in_valid, out_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic a_in_ready, a_out_valid, a_rs1_en, a_rs2_en, a_rd_we, a_word, a_illegal, a_ebreak, a_halt;
  logic [63:0] a_pc, a_imm;
  logic [6:0] a_opcode, a_funct7;
  logic [2:0] a_funct3, a_itype;
  logic [4:0] a_rs1, a_rs2, a_rd;
  logic [31:0] a_cnt;
  logic b_in_ready, b_out_valid, b_rs1_en, b_rs2_en, b_rd_we, b_word, b_illegal, b_ebreak, b_halt;
  logic [31:0] b_pc, b_imm;
  logic [6:0] b_opcode, b_funct7;
  logic [2:0] b_funct3, b_itype;
  logic [4:0] b_rs1, b_rs2, b_rd;
  logic [31:0] b_cnt;
  idu_pipe #(.XLEN(64), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_opcode(a_opcode), .out_funct3(a_funct3), .out_funct7(a_funct7),
    .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_rs1_en(a_rs1_en), .out_rs2_en(a_rs2_en),
    .out_rd_we(a_rd_we), .out_itype(a_itype), .out_imm(a_imm), .out_word(a_word),
    .out_illegal(a_illegal), .out_ebreak(a_ebreak), .halt(a_halt), .decode_cnt(a_cnt));
  idu_pipe #(.XLEN(32), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_pc(in_pc[31:0]), .in_inst(in_inst), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_opcode(b_opcode), .out_funct3(b_funct3), .out_funct7(b_funct7),
    .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_rs1_en(b_rs1_en), .out_rs2_en(b_rs2_en),
    .out_rd_we(b_rd_we), .out_itype(b_itype), .out_imm(b_imm), .out_word(b_word),
    .out_illegal(b_illegal), .out_ebreak(b_ebreak), .halt(b_halt), .decode_cnt(b_cnt));
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [2:0]  it64, it32;
    logic [4:0]  rd, rs1;
    logic [2:0]  en;
    logic [63:0] imm;
    logic        w, eb;
  } vec_t;
  vec_t qa[$], qb[$];
  vec_t ea, eb;
  int errors = 0, checks = 0;
  logic [63:0] pc_n = 64'h0000_0040_8000_1000;
  logic pv = 0, pr = 0, pf = 0;
  logic [63:0] ppc, pimm;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  function automatic vec_t mk(input logic [31:0] inst, input logic [2:0] it64, input logic [2:0] it32,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [2:0] en,
                              input logic [63:0] imm, input logic w, input logic ebk);
    vec_t v;
    v.pc = '0; v.inst = inst; v.it64 = it64; v.it32 = it32; v.rd = rd; v.rs1 = rs1;
    v.en = en; v.imm = imm; v.w = w; v.eb = ebk;
    return v;
  endfunction
  always @(negedge clk) begin
    if (a_out_valid && out_ready) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: got bundle pc=%0h want none", a_pc);
      end else begin
        ea = qa.pop_front();
        chk("a_pc", a_pc, ea.pc);
        chk("a_opcode", 64'(a_opcode), 64'(ea.inst[6:0]));
        chk("a_rd", 64'(a_rd), 64'(ea.rd));
        if (ea.it64 != 3'd7) chk("a_rs1", 64'(a_rs1), 64'(ea.rs1));
        chk("a_en", 64'({a_rs1_en, a_rs2_en, a_rd_we}), 64'(ea.en));
        chk("a_itype", 64'(a_itype), 64'(ea.it64));
        chk("a_imm", a_imm, ea.imm);
        chk("a_word", 64'(a_word), 64'(ea.w));
        chk("a_illegal", 64'(a_illegal), 64'(ea.it64 == 3'd7));
        chk("a_ebreak", 64'(a_ebreak), 64'(ea.eb));
      end
    end
    if (a_out_valid && !out_ready) chk("stall_in_ready", 64'(a_in_ready), 64'd0);
    if (pv && !pr && !pf) begin
      chk("hold_valid", 64'(a_out_valid), 64'd1);
      chk("hold_pc", a_pc, ppc);
      chk("hold_imm", a_imm, pimm);
    end
    pv = a_out_valid; pr = out_ready; pf = flush; ppc = a_pc; pimm = a_imm;
  end
  always @(negedge clk) begin
    if (b_out_valid && out_ready) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got bundle pc=%0h want none", b_pc);
      end else begin
        eb = qb.pop_front();
        chk("b_pc", 64'(b_pc), 64'(eb.pc[31:0]));
        chk("b_rd", 64'(b_rd), 64'(eb.rd));
        if (eb.it32 != 3'd7) chk("b_rs1", 64'(b_rs1), 64'(eb.rs1));
        chk("b_en", 64'({b_rs1_en, b_rs2_en, b_rd_we}), eb.it32 == 3'd7 ? 64'd0 : 64'(eb.en));
        chk("b_itype", 64'(b_itype), 64'(eb.it32));
        chk("b_imm", 64'(b_imm), eb.it32 == 3'd7 ? 64'd0 : 64'(eb.imm[31:0]));
        chk("b_word", 64'(b_word), 64'd0);
        chk("b_illegal", 64'(b_illegal), 64'(eb.it32 == 3'd7));
        chk("b_ebreak", 64'(b_ebreak), 64'(eb.eb));
      end
    end
  end
  task automatic send(input vec_t v);
    int n;
    v.pc = pc_n;
    pc_n = pc_n + 64'd4;
    in_valid = 1; in_inst = v.inst; in_pc = v.pc; n = 0;
    while (!a_in_ready && n < 50) begin
      @(posedge clk); #3; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready got 0 want 1 for inst %h", v.inst);
      in_valid = 0;
      return;
    end
    @(posedge clk);
    qa.push_back(v); qb.push_back(v);
    #3;
    in_valid = 0;
    chk("latency_valid", 64'(a_out_valid), 64'd1);
    chk("latency_pc", a_pc, v.pc);
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
      @(posedge clk); #3; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", qa.size() + qb.size());
    end
  endtask
  initial begin
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1; in_pc = '0; in_inst = '0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_valid", 64'(a_out_valid), 64'd0);
    chk("rst_halt", 64'(a_halt), 64'd0);
    chk("rst_cnt", 64'(a_cnt), 64'd0);
    chk("rst_itype", 64'(a_itype), 64'd0);
    chk("rst_imm", a_imm, 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_b_valid", 64'(b_out_valid), 64'd0);
    rst_n = 1;
    send(mk(32'hFFF0_0293, 3'd1, 3'd1, 5'd5, 5'd0, 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0));
    drain();
    chk("cnt_addi", 64'(a_cnt), 64'd1);
    chk("b_cnt_addi", 64'(b_cnt), 64'd1);
    send(mk(32'h8000_00B7, 3'd4, 3'd4, 5'd1, 5'd0, 3'b001, 64'hFFFF_FFFF_8000_0000, 0, 0));
    send(mk(32'hFE00_0EE3, 3'd3, 3'd3, 5'd29, 5'd0, 3'b110, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0));
    send(mk(32'h0010_006F, 3'd5, 3'd5, 5'd0, 5'd0, 3'b000, 64'h800, 0, 0));
    drain();
    chk("cnt_four", 64'(a_cnt), 64'd4);
    fork
      begin
        send(mk(32'h0070_819B, 3'd1, 3'd7, 5'd3, 5'd1, 3'b101, 64'h7, 1, 0));
        send(mk(32'h0000_007F, 3'd7, 3'd7, 5'd0, 5'd0, 3'b000, 64'h0, 0, 0));
        send(mk(32'h0031_03B3, 3'd0, 3'd0, 5'd7, 5'd2, 3'b111, 64'h0, 0, 0));
        send(mk(32'hFE41_2C23, 3'd2, 3'd2, 5'd24, 5'd2, 3'b110, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0));
      end
      begin
        @(posedge clk); #2;
        out_ready = 0;
        repeat (3) @(posedge clk);
        #2;
        out_ready = 1;
      end
    join
    drain();
    chk("cnt_stream", 64'(a_cnt), 64'd8);
    chk("b_cnt_stream", 64'(b_cnt), 64'd8);
    send(mk(32'h0000_0073, 3'd6, 3'd6, 5'd0, 5'd0, 3'b000, 64'h0, 0, 0));
    drain();
    chk("cnt_ecall", 64'(a_cnt), 64'd9);
    in_valid = 1; in_inst = 32'h0031_03B3; in_pc = pc_n; flush = 1;
    @(posedge clk); #3;
    flush = 0; in_valid = 0;
    chk("flush_valid", 64'(a_out_valid), 64'd0);
    chk("b_flush_valid", 64'(b_out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    chk("flush_cnt", 64'(a_cnt), 64'd9);
    chk("flush_halt", 64'(a_halt), 64'd0);
    send(mk(32'h0010_0073, 3'd6, 3'd6, 5'd0, 5'd0, 3'b000, 64'h0, 0, 1));
    in_valid = 1; in_inst = 32'hFFF0_0293; in_pc = pc_n;
    repeat (3) @(posedge clk);
    #3;
    chk("halt_set", 64'(a_halt), 64'd1);
    chk("b_halt_set", 64'(b_halt), 64'd1);
    chk("halt_in_ready", 64'(a_in_ready), 64'd0);
    chk("halt_valid", 64'(a_out_valid), 64'd0);
    drain();
    chk("cnt_ebreak", 64'(a_cnt), 64'd10);
    in_valid = 0; rst_n = 0;
    @(posedge clk); #3;
    rst_n = 1;
    chk("rerst_halt", 64'(a_halt), 64'd0);
    chk("rerst_valid", 64'(a_out_valid), 64'd0);
    chk("rerst_cnt", 64'(a_cnt), 64'd0);
    chk("rerst_in_ready", 64'(a_in_ready), 64'd1);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
